timer_controller: RTL and testbench
===================================

// Module: timer_controller
// PURPOSE
//  Game Boy timer unit (DIV/TIMA/TMA/TAC) driven by a single-cycle tick enable from a clock divider.
//  Schedules TIMA increments from a free-running prescale counter and sequences overflow reload and interrupt.
//  Sits on the CPU I/O bus at FF04-FF07; irq feeds the interrupt controller's timer bit (IF[2]).
// PARAMETERS
//  CNT_WIDTH   16        width of internal prescale counter; DIV = cnt[CNT_WIDTH-1:CNT_WIDTH-8]
//  DIV_RESET   8'h00     value of cnt[15:8] after reset
// PORTS
//  clock      in   1  system clock; single clock domain
//  reset      in   1  synchronous, active-high
//  tick_en    in   1  one-clock pulse per Game Boy machine tick (from divider)
//  reg_sel    in   2  00=DIV 01=TIMA 10=TMA 11=TAC
//  wr_en      in   1  write strobe, sampled every clock (not gated by tick_en)
//  data_in    in   8  write data
//  data_out   out  8  registered read data for reg_sel
//  irq        out  1  one-clock timer interrupt pulse
// BEHAVIOUR
//  Reset: cnt={DIV_RESET,8'h00}, TIMA=0, TMA=0, TAC=0, state=RUN, irq=0, data_out=0.
//  cnt increments by 1 on each tick_en; wraps 16'hFFFF->0. Write to DIV (any data) clears all of cnt to 0.
//  Select bit s from TAC[1:0]: 00->9, 01->3, 10->5, 11->7 (periods 1024/16/64/256 ticks).
//  TIMA increment: on tick_en with TAC[2]=1 and cnt[s:0]=all ones (carry out of bit s).
//  Reads: data_out <= mux(reg_sel) every clock, 1-cycle latency; TAC reads as {5'b11111,TAC[2:0]}.
//  Overflow FSM:
//   RUN: increment of TIMA=8'hFF -> TIMA=8'h00, go OVF_WAIT.
//   OVF_WAIT: next tick_en -> TIMA<=TMA, irq=1 for exactly one clock, go RUN.
//    CPU write to TIMA while in OVF_WAIT -> TIMA=data_in, reload and irq cancelled, go RUN.
//   Reload clock: a TIMA write in the same clock is ignored (TMA wins); a TMA write
//    in the same clock loads the new TMA value into TIMA.
//  Simultaneous events:
//   TIMA write and TIMA increment same clock -> write wins, no increment.
//   TAC write and tick_en same clock -> old TAC governs that tick; new TAC from next tick.
//   DIV write and tick_en same clock -> cnt=0 (write wins).
//  reset mid-operation (any state, incl. OVF_WAIT) -> reset values above; pending irq dropped.
//  irq never asserted for more than one clock; no increment occurs while tick_en=0.
// CONFIGURATION
//  TIMER_EDGE_GLITCH_EN defined: TIMA increments on falling edge of (cnt[s] & TAC[2]) sampled
//   every clock, reproducing DMG glitches: DIV write while cnt[s]=1, clearing TAC[2] while
//   cnt[s]=1, or changing TAC[1:0] from a high bit to a low bit each cause one extra increment.
//  Not defined: carry rule above only; DIV/TAC writes never cause increments.
// TESTING
//  TAC=3'b101, TIMA=0: 16 tick_en -> TIMA=1; 64 tick_en -> TIMA=4; DIV unchanged until tick 256.
//  TMA=8'hAB, TIMA=8'hFF, TAC=3'b101: overflow tick -> TIMA=00; next tick -> TIMA=AB, irq 1 clock.
//  Overflow then write TIMA=8'h55 before next tick -> TIMA=55, no irq, no reload.
//  Reload clock with TMA write 8'h12 -> TIMA=12, irq=1; same-clock TIMA write 8'h77 ignored.
//  TAC=3'b100, cnt=16'h0200, write DIV -> cnt=0; TIMA+1 only with TIMER_EDGE_GLITCH_EN.
//  Assert reset in OVF_WAIT -> all regs 0, irq never pulses; read TAC after reset -> 8'hF8.

Source files
------------

// File: rtl/timer_controller.sv
// Game Boy timer unit: DIV/TIMA/TMA/TAC at FF04-FF07 with overflow reload sequencing and a one-clock irq pulse.
// Optional macro TIMER_EDGE_GLITCH_EN switches TIMA increments to the DMG falling-edge detector (with its write glitches).
module timer_controller #(
    parameter int         CNT_WIDTH = 16,
    parameter logic [7:0] DIV_RESET = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_en,
    input  logic [1:0] reg_sel,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_RESET = {DIV_RESET, {(CNT_WIDTH-8){1'b0}}};

    typedef enum logic {
        ST_RUN,
        ST_OVF_WAIT
    } state_t;

    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic [7:0]           tima_reg, tima_next;
    logic [7:0]           tma_reg, tma_next;
    logic [2:0]           tac_reg, tac_next;
    state_t               state_reg, state_next;
    logic                 irq_reg, irq_next;
    logic [7:0]           data_out_reg, data_out_next;

    logic wr_div, wr_tima, wr_tma, wr_tac;
    logic inc_event;

    assign wr_div  = wr_en && (reg_sel == 2'b00);
    assign wr_tima = wr_en && (reg_sel == 2'b01);
    assign wr_tma  = wr_en && (reg_sel == 2'b10);
    assign wr_tac  = wr_en && (reg_sel == 2'b11);

    always_comb begin
        cnt_next = cnt_reg;
        if (wr_div) begin
            cnt_next = '0;
        end else if (tick_en) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign tma_next = wr_tma ? data_in : tma_reg;
    assign tac_next = wr_tac ? data_in[2:0] : tac_reg;

    // Prescale taps, indexed by TAC[1:0]: bit 9, 3, 5, 7.
`ifdef TIMER_EDGE_GLITCH_EN
    logic [3:0] tap_vec, tap_next_vec;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tap
            localparam int TAP = (gi == 0) ? 9 : (gi == 1) ? 3 : (gi == 2) ? 5 : 7;
            assign tap_vec[gi]      = cnt_reg[TAP];
            assign tap_next_vec[gi] = cnt_next[TAP];
        end
    endgenerate

    // Falling edge of (selected tap AND enable) between this clock and the next.
    assign inc_event = tap_vec[tac_reg[1:0]] & tac_reg[2]
                     & ~(tap_next_vec[tac_next[1:0]] & tac_next[2]);
`else
    logic [3:0] carry_vec;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tap
            localparam int TAP = (gi == 0) ? 9 : (gi == 1) ? 3 : (gi == 2) ? 5 : 7;
            assign carry_vec[gi] = &cnt_reg[TAP:0];
        end
    endgenerate

    // Carry out of the selected bit on a tick; the registered (old) TAC governs.
    assign inc_event = tick_en & tac_reg[2] & carry_vec[tac_reg[1:0]];
`endif

    always_comb begin
        state_next = state_reg;
        tima_next  = tima_reg;
        irq_next   = 1'b0;
        unique case (state_reg)
            ST_RUN: begin
                if (wr_tima) begin
                    tima_next = data_in;
                end else if (inc_event) begin
                    if (tima_reg == 8'hFF) begin
                        tima_next  = 8'h00;
                        state_next = ST_OVF_WAIT;
                    end else begin
                        tima_next = tima_reg + 8'd1;
                    end
                end
            end
            ST_OVF_WAIT: begin
                // Reload takes TMA including a same-clock TMA write; a same-clock TIMA write is lost.
                if (tick_en) begin
                    tima_next  = tma_next;
                    irq_next   = 1'b1;
                    state_next = ST_RUN;
                end else if (wr_tima) begin
                    tima_next  = data_in;
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        data_out_next = 8'h00;
        unique case (reg_sel)
            2'b00: data_out_next = cnt_reg[CNT_WIDTH-1 -: 8];
            2'b01: data_out_next = tima_reg;
            2'b10: data_out_next = tma_reg;
            2'b11: data_out_next = {5'b11111, tac_reg};
            default: data_out_next = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg      <= CNT_RESET;
            tima_reg     <= 8'h00;
            tma_reg      <= 8'h00;
            tac_reg      <= 3'b000;
            state_reg    <= ST_RUN;
            irq_reg      <= 1'b0;
            data_out_reg <= 8'h00;
        end else begin
            cnt_reg      <= cnt_next;
            tima_reg     <= tima_next;
            tma_reg      <= tma_next;
            tac_reg      <= tac_next;
            state_reg    <= state_next;
            irq_reg      <= irq_next;
            data_out_reg <= data_out_next;
        end
    end

    assign data_out = data_out_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_timer_controller.sv
// Self-checking bench for timer_controller: directed vector table, hand-written corner sequences,
// then randomized bus/tick traffic compared against a behavioural model of the timer rules.
module tb_timer_controller;

    logic       clock;
    logic       reset;
    logic       tick_en;
    logic [1:0] reg_sel;
    logic       wr_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       irq;

    int checks   = 0;
    int failures = 0;
    int irq_count = 0;
    logic irq_prev = 1'b0;

    timer_controller dut (
        .clock    (clock),
        .reset    (reset),
        .tick_en  (tick_en),
        .reg_sel  (reg_sel),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // irq must never stay high for two consecutive clocks
    always @(negedge clock) begin
        if (irq) begin
            irq_count++;
            checks++;
            if (irq_prev) begin
                failures++;
                $display("FAIL irq_width: irq high two clocks in a row, required single-clock pulse");
            end
        end
        irq_prev <= irq;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h required %02h", name, act, exp);
        end else begin
            $display("ok   %s: %02h", name, act);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick_en = 1'b0; wr_en = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] sel, input logic [7:0] d);
        reg_sel = sel; data_in = d; wr_en = 1'b1;
        @(posedge clock); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        tick_en = 1'b1;
        repeat (n) begin
            @(posedge clock); #1;
        end
        tick_en = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] sel, output logic [7:0] v);
        reg_sel = sel; wr_en = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        v = data_out;
    endtask

    typedef struct {
        logic       wr;
        logic [1:0] wsel;
        logic [7:0] wdata;
        int         ticks;
        logic [1:0] rsel;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[12];

    // behavioural model state for the random phase
    int   m_cnt, m_tima, m_tma, m_tac;
    bit   m_pend;
    int   e_dout;
    bit   e_irq;
    int   periods[4];

    task automatic model_step(input bit r, input bit tk, input bit w, input int sel, input int d);
        int  period;
        bit  inc, w_div, w_tima, w_tma, w_tac;
        int  new_tma;
        if (r) begin
            m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_pend = 0;
            e_dout = 0; e_irq = 0;
            return;
        end
        w_div  = w && sel == 0;
        w_tima = w && sel == 1;
        w_tma  = w && sel == 2;
        w_tac  = w && sel == 3;
        case (sel)
            0: e_dout = (m_cnt >> 8) & 255;
            1: e_dout = m_tima;
            2: e_dout = m_tma;
            default: e_dout = 248 | m_tac;
        endcase
        period  = periods[m_tac & 3];
        inc     = tk && (m_tac & 4) != 0 && (m_cnt % period) == period - 1;
        new_tma = w_tma ? d : m_tma;
        e_irq   = 0;
        if (m_pend) begin
            if (tk) begin
                m_tima = new_tma; e_irq = 1; m_pend = 0;
            end else if (w_tima) begin
                m_tima = d; m_pend = 0;
            end
        end else if (w_tima) begin
            m_tima = d;
        end else if (inc) begin
            m_tima = (m_tima + 1) % 256;
            if (m_tima == 0) m_pend = 1;
        end
        if (w_div) m_cnt = 0;
        else if (tk) m_cnt = (m_cnt + 1) % 65536;
        m_tma = new_tma;
        if (w_tac) m_tac = d & 7;
    endtask

    initial begin
        logic [7:0] v;
        int irq_before;

        reset = 1'b1; tick_en = 1'b0; reg_sel = 2'b00; wr_en = 1'b0; data_in = 8'h00;
        periods[0] = 1024; periods[1] = 16; periods[2] = 64; periods[3] = 256;

        vecs[0]  = '{1'b0, 2'd0, 8'h00, 0,   2'd3, 8'hF8, "rst_tac"};
        vecs[1]  = '{1'b0, 2'd0, 8'h00, 0,   2'd0, 8'h00, "rst_div"};
        vecs[2]  = '{1'b0, 2'd0, 8'h00, 0,   2'd1, 8'h00, "rst_tima"};
        vecs[3]  = '{1'b0, 2'd0, 8'h00, 0,   2'd2, 8'h00, "rst_tma"};
        vecs[4]  = '{1'b1, 2'd3, 8'h05, 0,   2'd3, 8'hFD, "tac_write"};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 16,  2'd1, 8'h01, "tima_after_16"};
        vecs[6]  = '{1'b0, 2'd0, 8'h00, 48,  2'd1, 8'h04, "tima_after_64"};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 191, 2'd0, 8'h00, "div_at_255"};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 1,   2'd0, 8'h01, "div_at_256"};
        vecs[9]  = '{1'b1, 2'd2, 8'hAB, 0,   2'd2, 8'hAB, "tma_write"};
        vecs[10] = '{1'b1, 2'd1, 8'hFF, 16,  2'd1, 8'h00, "overflow_zero"};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 1,   2'd1, 8'hAB, "reload_tma"};

        repeat (2) @(posedge clock);
        #1;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].wsel, vecs[i].wdata);
            if (vecs[i].ticks > 0) do_ticks(vecs[i].ticks);
            do_read(vecs[i].rsel, v);
            check(vecs[i].name, v, vecs[i].exp);
        end
        check("irq_count_reload", 8'(irq_count), 8'd1);

        // overflow then CPU write before the reload tick cancels reload and irq
        do_write(2'd0, 8'h00);
        do_write(2'd1, 8'hFF);
        do_ticks(16);
        irq_before = irq_count;
        do_write(2'd1, 8'h55);
        do_ticks(1);
        do_read(2'd1, v);
        check("cancel_tima", v, 8'h55);
        check("cancel_no_irq", 8'(irq_count - irq_before), 8'd0);

        // reload clock with same-clock TMA write: new TMA lands in TIMA, irq pulses next clock only
        do_write(2'd0, 8'h00);
        do_write(2'd1, 8'hFF);
        do_ticks(16);
        tick_en = 1'b1; reg_sel = 2'd2; data_in = 8'h12; wr_en = 1'b1;
        @(posedge clock); #1;
        tick_en = 1'b0; wr_en = 1'b0;
        check("reload_irq_high", 8'(irq), 8'd1);
        @(posedge clock); #1;
        check("reload_irq_low", 8'(irq), 8'd0);
        do_read(2'd1, v);
        check("reload_new_tma", v, 8'h12);

        // reload clock with same-clock TIMA write: write ignored
        do_write(2'd0, 8'h00);
        do_write(2'd1, 8'hFF);
        do_ticks(16);
        tick_en = 1'b1; reg_sel = 2'd1; data_in = 8'h77; wr_en = 1'b1;
        @(posedge clock); #1;
        tick_en = 1'b0; wr_en = 1'b0;
        do_read(2'd1, v);
        check("reload_ignores_tima_wr", v, 8'h12);

        // TIMA write on an incrementing tick: write wins
        do_write(2'd0, 8'h00);
        do_write(2'd1, 8'h20);
        do_ticks(15);
        tick_en = 1'b1; reg_sel = 2'd1; data_in = 8'h40; wr_en = 1'b1;
        @(posedge clock); #1;
        tick_en = 1'b0; wr_en = 1'b0;
        do_read(2'd1, v);
        check("tima_wr_beats_inc", v, 8'h40);

        // TAC write on an incrementing tick: old TAC governs that tick
        do_write(2'd0, 8'h00);
        do_write(2'd1, 8'h00);
        do_ticks(15);
        tick_en = 1'b1; reg_sel = 2'd3; data_in = 8'h04; wr_en = 1'b1;
        @(posedge clock); #1;
        tick_en = 1'b0; wr_en = 1'b0;
        do_read(2'd1, v);
        check("tac_wr_old_governs", v, 8'h01);

        // DIV write with cnt=0x0200 and TAC=100
        do_write(2'd3, 8'h04);
        do_write(2'd0, 8'h00);
        do_ticks(512);
        do_read(2'd0, v);
        check("div_at_0200", v, 8'h02);
        do_write(2'd1, 8'h00);
        do_write(2'd0, 8'h00);
        do_read(2'd0, v);
        check("div_cleared", v, 8'h00);
        do_read(2'd1, v);
`ifdef TIMER_EDGE_GLITCH_EN
        check("div_wr_glitch", v, 8'h01);
`else
        check("div_wr_no_glitch", v, 8'h00);
`endif

        // reset while waiting for reload
        do_write(2'd3, 8'h05);
        do_write(2'd2, 8'h99);
        do_write(2'd0, 8'h00);
        do_write(2'd1, 8'hFF);
        do_ticks(16);
        irq_before = irq_count;
        reset = 1'b1; tick_en = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; tick_en = 1'b0;
        do_read(2'd1, v);
        check("rst_ovf_tima", v, 8'h00);
        do_read(2'd2, v);
        check("rst_ovf_tma", v, 8'h00);
        do_read(2'd3, v);
        check("rst_ovf_tac", v, 8'hF8);
        do_read(2'd0, v);
        check("rst_ovf_div", v, 8'h00);
        do_ticks(4);
        check("rst_ovf_no_irq", 8'(irq_count - irq_before), 8'd0);

        // randomized traffic against the model
        do_reset();
        model_step(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            bit r, tk, w;
            int sel, d;
            r   = ($urandom_range(0, 499) == 0);
            tk  = $urandom_range(0, 1) == 1;
            w   = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 3);
            d   = $urandom_range(0, 255);
            if (sel == 1) d = 240 | (d & 15);
            if (sel == 3 && $urandom_range(0, 3) != 0) d = 4 | $urandom_range(0, 3);
            reset = r; tick_en = tk; wr_en = w; reg_sel = 2'(sel); data_in = 8'(d);
            model_step(r, tk, w, sel, d);
            @(posedge clock); #1;
            checks++;
            if (data_out !== 8'(e_dout) || irq !== e_irq) begin
                failures++;
                $display("FAIL random[%0d]: data_out=%02h irq=%0b required data_out=%02h irq=%0b",
                         i, data_out, irq, 8'(e_dout), e_irq);
            end
        end
        reset = 1'b0; tick_en = 1'b0; wr_en = 1'b0;
        @(posedge clock); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
